// File: rtl/gnr_node_bank.sv
`default_nettype none
// ============================================================================
// Module   : gnr_node_bank
// Brief    : Boolean GRN state bank with two state copies, per-node s0 update
//            period, fixed-point detection and a saturating step counter.
// Revision : 1.0 - initial release
// ============================================================================
module gnr_node_bank #(
    parameter int N_NODES   = 8,
    parameter int DIV_W     = 4,
    parameter int STABLE_TH = 4,
    parameter int STEP_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reset_nos,
    input  logic [N_NODES-1:0]         init_state,
    input  logic                       start_s0,
    input  logic                       start_s1,
    input  logic [N_NODES-1:0]         next_s0,
    input  logic [N_NODES-1:0]         next_s1,
    input  logic [N_NODES*DIV_W-1:0]   div_cfg,
    output logic [N_NODES-1:0]         s0,
    output logic [N_NODES-1:0]         s1,
    output logic [N_NODES-1:0]         mhc_s0,
    output logic [N_NODES-1:0]         mhc_s1,
    output logic [N_NODES-1:0]         upd_mask,
    output logic                       stable,
    output logic [STEP_W-1:0]          step_cnt
);

    localparam int SC_W = $clog2(STABLE_TH + 1);
    localparam logic [SC_W-1:0] C_STABLE_TH = SC_W'(STABLE_TH);

    logic [N_NODES-1:0] s0_q, s0_d;
    logic [N_NODES-1:0] s1_q, s1_d;
    logic [N_NODES-1:0] upd_mask_q, upd_mask_d;
    logic [DIV_W-1:0]   cnt_q [N_NODES];
    logic [DIV_W-1:0]   cnt_d [N_NODES];
    logic [SC_W-1:0]    stable_cnt_q, stable_cnt_d;
    logic               stable_q, stable_d;
    logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;

    always_comb begin
        s0_d         = s0_q;
        s1_d         = s1_q;
        upd_mask_d   = upd_mask_q;
        cnt_d        = cnt_q;
        stable_cnt_d = stable_cnt_q;
        step_cnt_d   = step_cnt_q;

        if (reset_nos) begin
            s0_d         = init_state;
            s1_d         = init_state;
            upd_mask_d   = '0;
            stable_cnt_d = '0;
            step_cnt_d   = '0;
            for (int i = 0; i < N_NODES; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            if (start_s0) begin
                // A node is written only when its period countdown has expired.
                for (int i = 0; i < N_NODES; i++) begin
                    if (cnt_q[i] == '0) begin
                        s0_d[i]       = next_s0[i];
                        cnt_d[i]      = div_cfg[i*DIV_W +: DIV_W];
                        upd_mask_d[i] = 1'b1;
                    end else begin
                        cnt_d[i]      = cnt_q[i] - 1'b1;
                        upd_mask_d[i] = 1'b0;
                    end
                end
                if (|(s0_d ^ s0_q)) begin
                    stable_cnt_d = '0;
                end else if (stable_cnt_q != C_STABLE_TH) begin
                    stable_cnt_d = stable_cnt_q + 1'b1;
                end
                if (step_cnt_q != '1) begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            if (start_s1) begin
                s1_d = next_s1;
            end
        end

        stable_d = (stable_cnt_d == C_STABLE_TH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q         <= '0;
            s1_q         <= '0;
            upd_mask_q   <= '0;
            stable_cnt_q <= '0;
            stable_q     <= 1'b0;
            step_cnt_q   <= '0;
            for (int i = 0; i < N_NODES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            upd_mask_q   <= upd_mask_d;
            stable_cnt_q <= stable_cnt_d;
            stable_q     <= stable_d;
            step_cnt_q   <= step_cnt_d;
            cnt_q        <= cnt_d;
        end
    end

    assign s0       = s0_q;
    assign s1       = s1_q;
    assign mhc_s0   = s0_q;
    assign mhc_s1   = s1_q;
    assign upd_mask = upd_mask_q;
    assign stable   = stable_q;
    assign step_cnt = step_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gnr_node_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_gnr_node_bank
// Brief    : Random and directed bench for gnr_node_bank against a strobe-index
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gnr_node_bank;

    localparam int N  = 8;
    localparam int DW = 4;
    localparam int TH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reset_nos = 1'b0;
    logic [N-1:0]  init_state = '0;
    logic          start_s0 = 1'b0;
    logic          start_s1 = 1'b0;
    logic [N-1:0]  next_s0 = '0;
    logic [N-1:0]  next_s1 = '0;
    logic [N*DW-1:0] div_cfg = '0;

    logic [N-1:0]  s0, s1, mhc_s0, mhc_s1, upd_mask;
    logic          stable;
    logic [15:0]   step_cnt;
    logic [N-1:0]  t_s0, t_s1, t_mhc_s0, t_mhc_s1, t_upd;
    logic          t_stable;
    logic [2:0]    t_step;

    int n_cmp = 0;
    int n_bad = 0;

    gnr_node_bank #(.N_NODES(N), .DIV_W(DW), .STABLE_TH(TH), .STEP_W(16)) dut (
        .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1), .next_s0(next_s0), .next_s1(next_s1),
        .div_cfg(div_cfg), .s0(s0), .s1(s1), .mhc_s0(mhc_s0), .mhc_s1(mhc_s1),
        .upd_mask(upd_mask), .stable(stable), .step_cnt(step_cnt)
    );

    gnr_node_bank #(.N_NODES(N), .DIV_W(DW), .STABLE_TH(TH), .STEP_W(3)) dut_sat (
        .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1), .next_s0(next_s0), .next_s1(next_s1),
        .div_cfg(div_cfg), .s0(t_s0), .s1(t_s1), .mhc_s0(t_mhc_s0), .mhc_s1(t_mhc_s1),
        .upd_mask(t_upd), .stable(t_stable), .step_cnt(t_step)
    );

    always #5 clk = ~clk;

    // Reference model: node i is written on strobe number next_upd[i] (counted
    // since the last reload), after which its next write is P+1 strobes later.
    int           m_k;
    int           m_next_upd [N];
    int           m_run;
    logic [N-1:0] m_s0, m_s1, m_upd;

    always @(posedge clk or posedge rst) begin : model
        int           k;
        logic [N-1:0] nw;
        logic [N-1:0] um;
        if (rst) begin
            m_k <= 0; m_run <= 0; m_s0 <= '0; m_s1 <= '0; m_upd <= '0;
            for (int i = 0; i < N; i++) m_next_upd[i] <= 1;
        end else if (reset_nos) begin
            m_k <= 0; m_run <= 0; m_s0 <= init_state; m_s1 <= init_state; m_upd <= '0;
            for (int i = 0; i < N; i++) m_next_upd[i] <= 1;
        end else begin
            if (start_s0) begin
                k  = m_k + 1;
                nw = m_s0;
                um = '0;
                for (int i = 0; i < N; i++) begin
                    if (k == m_next_upd[i]) begin
                        nw[i] = next_s0[i];
                        um[i] = 1'b1;
                        m_next_upd[i] <= k + int'(div_cfg[i*DW +: DW]) + 1;
                    end
                end
                m_k   <= k;
                m_upd <= um;
                m_s0  <= nw;
                m_run <= (nw != m_s0) ? 0 : m_run + 1;
            end
            if (start_s1) m_s1 <= next_s1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("s0", 32'(s0), 32'(m_s0));
        chk("s1", 32'(s1), 32'(m_s1));
        chk("mhc_s0", 32'(mhc_s0), 32'(m_s0));
        chk("mhc_s1", 32'(mhc_s1), 32'(m_s1));
        chk("upd_mask", 32'(upd_mask), 32'(m_upd));
        chk("stable", 32'(stable), 32'(m_run >= TH));
        chk("step_cnt", 32'(step_cnt), 32'((m_k > 65535) ? 65535 : m_k));
        chk("sat_s0", 32'(t_s0), 32'(m_s0));
        chk("sat_stable", 32'(t_stable), 32'(m_run >= TH));
        chk("sat_step_cnt", 32'(t_step), 32'((m_k > 7) ? 7 : m_k));
    end

    task automatic pulse(input logic s0s, input logic s1s, input logic rn,
                         input logic [N-1:0] n0, input logic [N-1:0] n1);
        @(negedge clk);
        start_s0 = s0s; start_s1 = s1s; reset_nos = rn;
        next_s0 = n0; next_s1 = n1;
        @(posedge clk);
        #1;
        start_s0 = 1'b0; start_s1 = 1'b0; reset_nos = 1'b0;
    endtask

    task automatic reload(input logic [N-1:0] init);
        init_state = init;
        pulse(1'b0, 1'b0, 1'b1, '0, '0);
    endtask

    logic [7:0] exp_s0_seq [6];
    logic [7:0] exp_upd_seq [6];

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s0", 32'(s0), 32'h0);
        chk("rst_step", 32'(step_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset/reload
        reload(8'hA5);
        chk("reload_s0", 32'(s0), 32'hA5);
        chk("reload_s1", 32'(s1), 32'hA5);
        chk("reload_step", 32'(step_cnt), 32'h0);
        chk("reload_stable", 32'(stable), 32'h0);

        // Divider: all periods 1
        div_cfg = {N{4'd1}};
        reload(8'h00);
        exp_s0_seq  = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
        exp_upd_seq = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        for (int i = 0; i < 6; i++) begin
            pulse(1'b1, 1'b0, 1'b0, ~s0, '0);
            chk("div_s0", 32'(s0), 32'(exp_s0_seq[i]));
            chk("div_upd", 32'(upd_mask), 32'(exp_upd_seq[i]));
        end

        // Mixed periods: node0 P=0, node1 P=2
        div_cfg = '0;
        div_cfg[7:4] = 4'd2;
        reload(8'h00);
        exp_s0_seq = '{8'h03, 8'h02, 8'h03, 8'h00, 8'h01, 8'h00};
        for (int i = 0; i < 6; i++) begin
            pulse(1'b1, 1'b0, 1'b0, ~s0, '0);
            chk("mix_s0_lo", 32'(s0[1:0]), 32'(exp_s0_seq[i][1:0]));
        end

        // Attractor
        div_cfg = '0;
        reload(8'h5A);
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1'b0, 1'b0, 8'h5A, '0);
            chk("attr_stable", 32'(stable), (i == 3) ? 32'h1 : 32'h0);
        end
        pulse(1'b1, 1'b0, 1'b0, 8'h5B, '0);
        chk("attr_drop", 32'(stable), 32'h0);

        // Simultaneous strobes, then reload winning over both strobes
        pulse(1'b1, 1'b1, 1'b0, 8'h0F, 8'hF0);
        chk("sim_s0", 32'(s0), 32'h0F);
        chk("sim_s1", 32'(s1), 32'hF0);
        init_state = 8'h3C;
        pulse(1'b1, 1'b1, 1'b1, 8'h0F, 8'hF0);
        chk("prio_s0", 32'(s0), 32'h3C);
        chk("prio_s1", 32'(s1), 32'h3C);
        chk("prio_step", 32'(step_cnt), 32'h0);

        // Saturation on the 3-bit counter instance
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0, 1'b0, 8'h3C, '0);
        chk("sat_step", 32'(t_step), 32'h7);
        chk("nosat_step", 32'(step_cnt), 32'd10);

        // Asynchronous reset between edges
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_s0", 32'(s0), 32'h0);
        chk("arst_s1", 32'(s1), 32'h0);
        chk("arst_step", 32'(step_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized phase
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            start_s0   = ($urandom_range(0, 3) != 0);
            start_s1   = ($urandom_range(0, 2) == 0);
            reset_nos  = ($urandom_range(0, 60) == 0);
            init_state = 8'($urandom);
            next_s1    = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       next_s0 = 8'($urandom);
                1:       next_s0 = s0 ^ (8'h1 << $urandom_range(0, 7));
                default: next_s0 = s0;
            endcase
            if ($urandom_range(0, 15) == 0) begin
                for (int i = 0; i < N; i++) div_cfg[i*DW +: DW] = 4'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 200) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        start_s0 = 1'b0; start_s1 = 1'b0; reset_nos = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
